// File: rtl/fpga_cfg_loader.sv
// Wishbone-fed configuration loader: buffers 32-bit words and shifts them MSB-first onto ccff_head.
// Build option CFG_LOADER_READBACK_EN adds a ccff_tail_i capture register readable at offset 0x14.
module fpga_cfg_loader #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        prog_clk_o,
  output logic        prog_reset_o,
  output logic        ccff_head_o,
  input  logic        ccff_tail_i,
  output logic        done_irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRST,
    S_LOAD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [DIV_W:0]  timer_reg;
  logic            ack_reg;
  logic [31:0]     dat_o_reg;
  logic            prst_hold_reg;
  logic [31:0]     bitcnt_reg;
  logic [DIV_W-1:0] clkdiv_reg;
  logic [31:0]     bits_left_reg;
  logic [4:0]      bit_idx_reg;
  logic [31:0]     shift_reg;
  logic            head_reg;
  logic            done_reg, underrun_reg, overflow_reg;
  logic [AW:0]     wr_ptr_reg, rd_ptr_reg;
  logic [31:0]     fifo_mem [FIFO_DEPTH];

  logic            bus_req, wr_en;
  logic            wr_ctrl, wr_status, wr_data, wr_bitcnt, wr_clkdiv;
  logic            start_cmd, abort_cmd, busy;
  logic            fifo_empty, fifo_full, fifo_pop, push_ok;
  logic [31:0]     fifo_word, rd_data, status_word;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W:0]  prst_last, shift_last;
  logic            shift_step, set_underrun, set_done;
  logic            unused_inputs;

  // Register writes land on the edge that ends the ack cycle.
  assign bus_req   = wbs_stb_i & wbs_cyc_i;
  assign wr_en     = ack_reg & bus_req & wbs_we_i;
  assign wr_ctrl   = wr_en && (wbs_adr_i[4:2] == 3'd0);
  assign wr_status = wr_en && (wbs_adr_i[4:2] == 3'd1);
  assign wr_data   = wr_en && (wbs_adr_i[4:2] == 3'd2);
  assign wr_bitcnt = wr_en && (wbs_adr_i[4:2] == 3'd3);
  assign wr_clkdiv = wr_en && (wbs_adr_i[4:2] == 3'd4);

  assign busy      = (state_reg != S_IDLE);
  assign abort_cmd = wr_ctrl & wbs_dat_i[1];
  assign start_cmd = wr_ctrl & wbs_dat_i[0] & ~wbs_dat_i[1] & ~busy;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign fifo_word  = fifo_mem[rd_ptr_reg[AW-1:0]];
  assign push_ok    = wr_data & (~fifo_full | fifo_pop);

  assign div_eff    = (clkdiv_reg == '0) ? DIV_W'(1) : clkdiv_reg;
  assign prst_last  = {div_eff, 1'b0} - (DIV_W+1)'(1);
  assign shift_last = {1'b0, div_eff} - (DIV_W+1)'(1);

  assign status_word = {26'd0, overflow_reg, underrun_reg, fifo_empty, fifo_full, done_reg, busy};

  always_comb begin
    state_next   = state_reg;
    fifo_pop     = 1'b0;
    shift_step   = 1'b0;
    set_underrun = 1'b0;
    set_done     = 1'b0;
    case (state_reg)
      S_IDLE: if (start_cmd) state_next = S_PRST;
      S_PRST: begin
        if (timer_reg == prst_last)
          state_next = (bits_left_reg == 32'd0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        if (fifo_empty) begin
          set_underrun = 1'b1;
        end else begin
          fifo_pop   = 1'b1;
          state_next = S_SHIFT_LO;
        end
      end
      S_SHIFT_LO: if (timer_reg == shift_last) state_next = S_SHIFT_HI;
      S_SHIFT_HI: begin
        if (timer_reg == shift_last) begin
          shift_step = 1'b1;
          if (bits_left_reg == 32'd1)      state_next = S_DONE;
          else if (bit_idx_reg == 5'd0)    state_next = S_LOAD;
          else                             state_next = S_SHIFT_LO;
        end
      end
      S_DONE: begin
        set_done   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (abort_cmd) begin
      state_next   = S_IDLE;
      fifo_pop     = 1'b0;
      shift_step   = 1'b0;
      set_underrun = 1'b0;
      set_done     = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg <= S_IDLE;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= (state_next != state_reg) ? '0 : timer_reg + (DIV_W+1)'(1);
    end
  end

  // ccff_head only moves on entry to SHIFT_LO, keeping it stable around the prog_clk rise.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bits_left_reg <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      head_reg      <= 1'b0;
    end else begin
      if (start_cmd) bits_left_reg <= bitcnt_reg;
      if (fifo_pop) begin
        shift_reg   <= fifo_word;
        bit_idx_reg <= 5'd31;
        head_reg    <= fifo_word[31];
      end else if (shift_step) begin
        shift_reg     <= {shift_reg[30:0], 1'b0};
        bit_idx_reg   <= bit_idx_reg - 5'd1;
        bits_left_reg <= bits_left_reg - 32'd1;
        if (state_next == S_SHIFT_LO) head_reg <= shift_reg[30];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) fifo_mem[wr_ptr_reg[AW-1:0]] <= wbs_dat_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (abort_cmd) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok)  wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (fifo_pop) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      prst_hold_reg <= 1'b1;
      bitcnt_reg    <= '0;
      clkdiv_reg    <= DIV_W'(1);
      done_reg      <= 1'b0;
      underrun_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      if (wr_ctrl)           prst_hold_reg <= wbs_dat_i[2];
      if (wr_bitcnt && !busy) bitcnt_reg   <= wbs_dat_i;
      if (wr_clkdiv && !busy) clkdiv_reg   <= wbs_dat_i[DIV_W-1:0];
      // Hardware set takes priority over a software clear in the same cycle.
      if (set_done)                           done_reg <= 1'b1;
      else if (wr_status && wbs_dat_i[1])     done_reg <= 1'b0;
      if (set_underrun)                       underrun_reg <= 1'b1;
      else if (wr_status && wbs_dat_i[4])     underrun_reg <= 1'b0;
      if (wr_data && fifo_full && !fifo_pop)  overflow_reg <= 1'b1;
      else if (wr_status && wbs_dat_i[5])     overflow_reg <= 1'b0;
    end
  end

`ifdef CFG_LOADER_READBACK_EN
  logic [31:0] rb_reg;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || start_cmd)
      rb_reg <= '0;
    else if (state_next == S_SHIFT_HI && state_reg != S_SHIFT_HI)
      rb_reg <= {rb_reg[30:0], ccff_tail_i};
  end

  assign unused_inputs = ^{wbs_sel_i, wbs_adr_i[31:5], wbs_adr_i[1:0]};
`else
  assign unused_inputs = ^{wbs_sel_i, wbs_adr_i[31:5], wbs_adr_i[1:0], ccff_tail_i};
`endif

  always_comb begin
    rd_data = '0;
    case (wbs_adr_i[4:2])
      3'd0: rd_data = {29'd0, prst_hold_reg, 2'b00};
      3'd1: rd_data = status_word;
      3'd3: rd_data = bitcnt_reg;
      3'd4: rd_data = 32'(clkdiv_reg);
`ifdef CFG_LOADER_READBACK_EN
      3'd5: rd_data = rb_reg;
`endif
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_reg   <= 1'b0;
      dat_o_reg <= '0;
    end else begin
      ack_reg   <= bus_req & ~ack_reg;
      dat_o_reg <= (bus_req && !ack_reg && !wbs_we_i) ? rd_data : '0;
    end
  end

  assign wbs_ack_o    = ack_reg;
  assign wbs_dat_o    = dat_o_reg;
  assign prog_clk_o   = (state_reg == S_SHIFT_HI);
  assign prog_reset_o = (state_reg == S_IDLE) ? prst_hold_reg : (state_reg == S_PRST);
  assign ccff_head_o  = head_reg;
  assign done_irq_o   = done_reg;

endmodule
